load_seq: RTL and testbench

- Sequencer for the load-width datapath (the reduce block) in the RISC-V pipelined core.
- Accepts one load per request from the Memory stage and issues a word-aligned read on a valid/ready data-memory port.
- Byte-aligns the returned word, drives reduce for sign/zero extension, and presents the result to Writeback.
- Stalls the pipeline while the access is outstanding.

---
 rtl/core_pkg.sv | 37 +++
 rtl/load_seq_reduce.sv | 28 ++
 rtl/load_seq.sv | 121 ++++++++++++
 tb/tb_load_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the load path of the pipelined core.
//   - WidthSrc encodings used by the Memory stage and the reduce block
//   - load_state_t: state encoding of the load sequencer FSM
//   - is_misaligned(): natural-alignment check for a load of a given width
package core_pkg;

    // Load width / extension codes. Bit 2 selects zero extension,
    // bits [1:0] select size (00 word, 01 byte, 10 halfword).
    localparam logic [2:0] WIDTH_W  = 3'b000;
    localparam logic [2:0] WIDTH_BS = 3'b001;
    localparam logic [2:0] WIDTH_HS = 3'b010;
    localparam logic [2:0] WIDTH_BU = 3'b101;
    localparam logic [2:0] WIDTH_HU = 3'b110;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4,
        FAULT = 3'd5
    } load_state_t;

    // Words must be 4-byte aligned, halfwords 2-byte aligned; bytes never fault.
    // Unknown codes are treated as byte accesses so they never raise a fault.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] width);
        logic mis;
        mis = 1'b0;
        case (width)
            WIDTH_W:            mis = (off != 2'b00);
            WIDTH_HS, WIDTH_HU: mis = off[0];
            default:            mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_seq_reduce.sv
// load_seq_reduce: the reduce block. Sign/zero extends the low byte or
// halfword of an already byte-aligned word according to WidthSrc.
// Ports:
//   data_i   [XLEN-1:0]  byte-aligned memory data (bits [7:0] = addressed byte)
//   width_i  [2:0]       load width/extension code (core_pkg encoding)
//   result_o [XLEN-1:0]  extended load result
module load_seq_reduce
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      width_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = data_i;
        case (width_i)
            WIDTH_BS: result_o = {{(XLEN-8){data_i[7]}}, data_i[7:0]};
            WIDTH_BU: result_o = {{(XLEN-8){1'b0}}, data_i[7:0]};
            WIDTH_HS: result_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
            WIDTH_HU: result_o = {{(XLEN-16){1'b0}}, data_i[15:0]};
            default:  result_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_seq.sv
// load_seq: load sequencer between the Memory stage and Writeback.
// Accepts one load at a time, checks natural alignment, issues a word-aligned
// read on a valid/ready memory port, byte-aligns the returned word, extends it
// via the reduce block and presents it to Writeback for one cycle.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   LoadReq/Addr/WidthSrc/RdIn    load request from the Memory stage
//   Flush                         kill the in-flight load
//   MemReqValid/MemReqReady/MemAddr   read request channel
//   MemRspValid/MemRspData        read response channel
//   Stall                         hold the upstream pipeline stages
//   LoadValid/Result/RdOut        writeback result (qualify with LoadValid)
//   MisalignedErr                 one-cycle pulse for a rejected load
module load_seq
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            LoadReq,
    input  logic [XLEN-1:0] Addr,
    input  logic [2:0]      WidthSrc,
    input  logic [4:0]      RdIn,
    input  logic            Flush,
    output logic            MemReqValid,
    input  logic            MemReqReady,
    output logic [XLEN-1:0] MemAddr,
    input  logic            MemRspValid,
    input  logic [XLEN-1:0] MemRspData,
    output logic            Stall,
    output logic            LoadValid,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      RdOut,
    output logic            MisalignedErr
);

    load_state_t     state_q;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      width_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] base_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rdout_q;

    logic            accept;
    logic            req_mis;
    logic [XLEN-1:0] aligned_data;
    logic [XLEN-1:0] reduce_out;

    // A flushed DONE cycle must not pick up a new load.
    assign accept  = LoadReq && ((state_q == IDLE) || (state_q == DONE && !Flush));
    assign req_mis = is_misaligned(Addr[1:0], WidthSrc);

    // Move the addressed byte down to bit 0.
    assign aligned_data = MemRspData >> {addr_q[1:0], 3'b000};

    load_seq_reduce #(.XLEN(XLEN)) u_reduce (
        .data_i   (base_q),
        .width_i  (width_q),
        .result_o (reduce_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            width_q  <= '0;
            rd_q     <= '0;
            base_q   <= '0;
            result_q <= '0;
            rdout_q  <= '0;
        end else begin
            // Capture the DONE-cycle result so Result/RdOut hold afterwards.
            if (state_q == DONE) begin
                result_q <= reduce_out;
                rdout_q  <= rd_q;
            end
            if (accept) begin
                addr_q  <= Addr;
                width_q <= WidthSrc;
                rd_q    <= RdIn;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (accept) state_q <= req_mis ? FAULT : REQ;
                    else        state_q <= IDLE;
                end
                REQ: begin
                    // A request already handed to memory must have its response drained.
                    if (Flush)            state_q <= MemReqReady ? DRAIN : IDLE;
                    else if (MemReqReady) state_q <= WAIT;
                end
                WAIT: begin
                    if (Flush) begin
                        state_q <= MemRspValid ? IDLE : DRAIN;
                    end else if (MemRspValid) begin
                        base_q  <= aligned_data;
                        state_q <= DONE;
                    end
                end
                DRAIN: begin
                    if (MemRspValid) state_q <= IDLE;
                end
                FAULT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MemReqValid   = (state_q == REQ);
    assign MemAddr       = {addr_q[XLEN-1:2], 2'b00};
    assign MisalignedErr = (state_q == FAULT);
    assign LoadValid     = (state_q == DONE) && !Flush;
    assign Result        = (state_q == DONE) ? reduce_out : result_q;
    assign RdOut         = (state_q == DONE) ? rd_q : rdout_q;
    // Upstream stalls from the cycle an aligned load is accepted until DONE.
    assign Stall         = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN)
                           || (accept && !req_mis);

endmodule

// File: tb/tb_load_seq.sv
// Randomized self-checking bench for load_seq with a transaction-level model.
module tb_load_seq;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        LoadReq, Flush, MemReqReady, MemRspValid;
    logic [31:0] Addr, MemRspData;
    logic [2:0]  WidthSrc;
    logic [4:0]  RdIn;
    logic        MemReqValid, Stall, LoadValid, MisalignedErr;
    logic [31:0] MemAddr, Result;
    logic [4:0]  RdOut;

    int checks   = 0;
    int failures = 0;

    logic [2:0] codes [5] = '{WIDTH_W, WIDTH_BS, WIDTH_HS, WIDTH_BU, WIDTH_HU};

    load_seq dut (
        .clk(clk), .reset(reset), .LoadReq(LoadReq), .Addr(Addr), .WidthSrc(WidthSrc),
        .RdIn(RdIn), .Flush(Flush), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady),
        .MemAddr(MemAddr), .MemRspValid(MemRspValid), .MemRspData(MemRspData),
        .Stall(Stall), .LoadValid(LoadValid), .Result(Result), .RdOut(RdOut),
        .MisalignedErr(MisalignedErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a width code.
    function automatic int size_of(input logic [2:0] w);
        if (w == WIDTH_W) return 4;
        if (w == WIDTH_HS || w == WIDTH_HU) return 2;
        return 1;
    endfunction

    function automatic bit ref_mis(input logic [31:0] a, input logic [2:0] w);
        return (a % size_of(w)) != 0;
    endfunction

    // Pick the addressed bytes out of the little-endian word and extend them.
    function automatic logic [31:0] ref_res(input logic [31:0] word, input logic [31:0] a,
                                            input logic [2:0] w);
        logic [31:0] v;
        v = word / (32'd1 << (8 * (a % 4)));
        case (w)
            WIDTH_BU: return v % 256;
            WIDTH_HU: return v % 65536;
            WIDTH_BS: return (v % 256 >= 128) ? (v % 256) - 32'd256 : v % 256;
            WIDTH_HS: return (v % 65536 >= 32768) ? (v % 65536) - 32'd65536 : v % 65536;
            default:  return word;
        endcase
    endfunction

    task automatic idle_inputs();
        LoadReq     = 1'b0;
        Flush       = 1'b0;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        Addr        = $urandom;
        WidthSrc    = 3'($urandom);
        RdIn        = 5'($urandom);
        MemRspData  = $urandom;
    endtask

    // One complete load: r ready-low cycles, response d cycles after the handshake.
    // keep_done leaves the bench inside the DONE cycle for a back-to-back request.
    task automatic load_txn(input logic [31:0] a, input logic [2:0] w, input logic [4:0] rd,
                            input int r, input int d, input logic [31:0] word, input bit keep_done);
        bit mis;
        logic [31:0] exp;
        mis = ref_mis(a, w);
        exp = ref_res(word, a, w);
        LoadReq = 1'b1; Addr = a; WidthSrc = w; RdIn = rd;
        Flush = 1'b0; MemReqReady = 1'b0; MemRspValid = 1'b0;
        #1 chk("stall_on_accept", Stall, 32'(!mis));
        @(negedge clk);
        if (mis) begin
            idle_inputs();
            LoadReq = 1'($urandom);
            #1;
            chk("mis_pulse", MisalignedErr, 1);
            chk("mis_no_req", MemReqValid, 0);
            chk("mis_no_stall", Stall, 0);
            chk("mis_no_lv", LoadValid, 0);
            @(negedge clk);
            idle_inputs();
            #1;
            chk("mis_pulse_end", MisalignedErr, 0);
            chk("mis_idle_req", MemReqValid, 0);
            return;
        end
        for (int i = 0; i <= r; i++) begin
            idle_inputs();
            LoadReq     = 1'($urandom);
            MemRspValid = 1'($urandom);
            MemReqReady = (i == r);
            #1;
            chk("req_valid", MemReqValid, 1);
            chk("req_addr", MemAddr, {a[31:2], 2'b00});
            chk("req_stall", Stall, 1);
            chk("req_no_lv", LoadValid, 0);
            @(negedge clk);
        end
        for (int j = 0; j <= d; j++) begin
            idle_inputs();
            LoadReq     = 1'($urandom);
            MemRspValid = (j == d);
            if (j == d) MemRspData = word;
            #1;
            chk("wait_stall", Stall, 1);
            chk("wait_no_req", MemReqValid, 0);
            chk("wait_no_lv", LoadValid, 0);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("done_lv", LoadValid, 1);
        chk("done_result", Result, exp);
        chk("done_rd", RdOut, 32'(rd));
        chk("done_stall", Stall, 0);
        if (!keep_done) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("post_lv", LoadValid, 0);
            chk("result_hold", Result, exp);
            chk("rd_hold", RdOut, 32'(rd));
        end
    endtask

    // Accept an aligned word load and advance into the WAIT cycle.
    task automatic start_to_wait(input logic [31:0] a);
        LoadReq = 1'b1; Addr = a; WidthSrc = WIDTH_W; RdIn = 5'd3;
        @(negedge clk);
        idle_inputs();
        MemReqReady = 1'b1;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", MemReqValid, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_lv", LoadValid, 0);
        chk("rst_result", Result, 0);
        chk("rst_rd", RdOut, 0);
        chk("rst_mis", MisalignedErr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed loads: zero wait, byte/halfword extension, misaligned, ready stall.
        load_txn(32'h1000_0004, WIDTH_W,  5'd7,  0, 0, 32'hDEAD_BEEF, 0);
        load_txn(32'h1000_0007, WIDTH_BS, 5'd8,  0, 0, 32'h80AA_BBCC, 0);
        load_txn(32'h1000_0007, WIDTH_BU, 5'd9,  0, 0, 32'h80AA_BBCC, 0);
        load_txn(32'h1000_0002, WIDTH_HS, 5'd10, 0, 0, 32'h8001_1234, 0);
        load_txn(32'h1000_0002, WIDTH_W,  5'd11, 0, 0, 32'h1234_5678, 0);
        load_txn(32'h1000_0010, WIDTH_W,  5'd12, 3, 0, 32'hCAFE_F00D, 0);

        // Back-to-back: new request in DONE gets a request the next cycle.
        load_txn(32'h2000_0000, WIDTH_W,  5'd1, 0, 0, 32'h1111_2222, 1);
        load_txn(32'h2000_0006, WIDTH_HU, 5'd2, 0, 1, 32'h9876_5432, 0);

        // Flush in WAIT, response two cycles later is drained.
        start_to_wait(32'h3000_0000);
        Flush = 1'b1;
        #1 chk("fw_stall", Stall, 1);
        @(negedge clk);
        idle_inputs();
        LoadReq = 1'b1; Addr = 32'h3000_0100; WidthSrc = WIDTH_W;
        #1;
        chk("drain_stall", Stall, 1);
        chk("drain_no_lv", LoadValid, 0);
        @(negedge clk);
        idle_inputs();
        MemRspValid = 1'b1;
        #1;
        chk("drain_stall2", Stall, 1);
        chk("drain_no_lv2", LoadValid, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("drain_idle_stall", Stall, 0);
        chk("drain_idle_req", MemReqValid, 0);
        chk("drain_idle_lv", LoadValid, 0);
        load_txn(32'h3000_0008, WIDTH_W, 5'd4, 1, 2, 32'hA5A5_5A5A, 0);

        // Flush in REQ before the handshake.
        LoadReq = 1'b1; Addr = 32'h4000_0000; WidthSrc = WIDTH_W;
        @(negedge clk);
        idle_inputs();
        Flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("freq_req_drop", MemReqValid, 0);
        chk("freq_stall", Stall, 0);

        // Flush in REQ with a handshake: the response must still be drained.
        LoadReq = 1'b1; Addr = 32'h4000_0004; WidthSrc = WIDTH_W;
        @(negedge clk);
        idle_inputs();
        Flush = 1'b1; MemReqReady = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("frh_drain_stall", Stall, 1);
        chk("frh_no_req", MemReqValid, 0);
        MemRspValid = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("frh_idle_stall", Stall, 0);
        chk("frh_no_lv", LoadValid, 0);

        // Flush in WAIT together with the response: straight to IDLE.
        start_to_wait(32'h4000_0008);
        Flush = 1'b1; MemRspValid = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("fwr_stall", Stall, 0);
        chk("fwr_no_lv", LoadValid, 0);
        chk("fwr_no_req", MemReqValid, 0);

        // Flush in DONE: no LoadValid, no acceptance.
        load_txn(32'h5000_0000, WIDTH_W, 5'd5, 0, 0, 32'h0BAD_CAFE, 1);
        Flush = 1'b1; LoadReq = 1'b1; Addr = 32'h5000_0040; WidthSrc = WIDTH_W;
        #1;
        chk("fdone_lv", LoadValid, 0);
        chk("fdone_stall", Stall, 0);
        @(negedge clk);
        idle_inputs();
        #1 chk("fdone_no_accept", MemReqValid, 0);

        // Flush in FAULT keeps the error pulse.
        LoadReq = 1'b1; Addr = 32'h5000_0001; WidthSrc = WIDTH_HS;
        @(negedge clk);
        idle_inputs();
        Flush = 1'b1;
        #1 chk("ffault_pulse", MisalignedErr, 1);
        @(negedge clk);
        idle_inputs();

        // Reset during WAIT.
        start_to_wait(32'h6000_0004);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("rw_req", MemReqValid, 0);
        chk("rw_addr", MemAddr, 0);
        chk("rw_stall", Stall, 0);
        chk("rw_lv", LoadValid, 0);
        chk("rw_result", Result, 0);
        chk("rw_rd", RdOut, 0);
        chk("rw_mis", MisalignedErr, 0);
        load_txn(32'h6000_0008, WIDTH_BS, 5'd6, 0, 0, 32'h0000_7F00, 0);

        // Randomized loads.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [2:0]  w;
            bit          keep;
            a    = $urandom;
            w    = codes[$urandom_range(0, 4)];
            keep = !ref_mis(a, w) && ($urandom_range(0, 1) == 1) && (k != 59);
            load_txn(a, w, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom, keep);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
